// File: rtl/wb_timeout_bridge_if.sv
// Wishbone bundle for the timeout bridge: upstream (wbs_*) side from the
// management master and downstream (wbm_*) side to the harness.
interface wb_timeout_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        timeout_o;

  // bridge view
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbm_ack_i, wbm_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output timeout_o
  );

  // environment view (upstream master plus downstream harness)
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbm_ack_i, wbm_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  timeout_o
  );
endinterface

// File: rtl/wb_timeout_bridge.sv
// Wishbone stage that forwards requests downstream and self-completes them with
// ERR_DATA after TIMEOUT unacked cycles; a local status register logs timeouts.
module wb_timeout_bridge #(
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [31:0] STATUS_ADDR = 32'h30000F00,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input logic                wb_clk_i,
  input logic                wb_rst_i,
  wb_timeout_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FWD, LOCAL, DONE} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_adr, req_dat;
  logic [7:0]  wait_cnt;
  logic [31:0] cap_dat;
  logic        err;
  logic [7:0]  timeout_cnt;
  logic [15:0] last_adr;

  logic        req_take, cap_en, tmo_hit, clr_stat, fwd;
  logic [31:0] cap_val, status_word;

  assign status_word = {err, 7'b0, timeout_cnt, last_adr};
  assign req_take    = (state == IDLE) && bus.wbs_cyc_i && bus.wbs_stb_i;
  assign fwd         = (state == FWD);

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    cap_val   = '0;
    tmo_hit   = 1'b0;
    clr_stat  = 1'b0;
    case (state)
      IDLE: begin
        if (req_take) state_nxt = (bus.wbs_adr_i == STATUS_ADDR) ? LOCAL : FWD;
      end
      FWD: begin
        // a master abort drops the transfer silently; an ack on the limit cycle still succeeds
        if (!bus.wbs_cyc_i) begin
          state_nxt = IDLE;
        end else if (bus.wbm_ack_i) begin
          cap_en    = 1'b1;
          cap_val   = req_we ? 32'h0 : bus.wbm_dat_i;
          state_nxt = DONE;
        end else if (wait_cnt == LIMIT) begin
          cap_en    = 1'b1;
          cap_val   = req_we ? 32'h0 : ERR_DATA;
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      LOCAL: begin
        cap_en    = 1'b1;
        cap_val   = req_we ? 32'h0 : status_word;
        clr_stat  = req_we && req_sel[3];
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      req_we      <= 1'b0;
      req_sel     <= '0;
      req_adr     <= '0;
      req_dat     <= '0;
      wait_cnt    <= '0;
      cap_dat     <= '0;
      err         <= 1'b0;
      timeout_cnt <= '0;
      last_adr    <= '0;
    end else begin
      state <= state_nxt;
      if (req_take) begin
        req_we   <= bus.wbs_we_i;
        req_sel  <= bus.wbs_sel_i;
        req_adr  <= bus.wbs_adr_i;
        req_dat  <= bus.wbs_dat_i;
        wait_cnt <= '0;
      end else if (fwd) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (cap_en) cap_dat <= cap_val;
      if (tmo_hit) begin
        err      <= 1'b1;
        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
        last_adr <= req_adr[15:0];
      end else if (clr_stat) begin
        err         <= 1'b0;
        timeout_cnt <= '0;
        last_adr    <= '0;
      end
    end
  end

  assign bus.wbm_cyc_o = fwd;
  assign bus.wbm_stb_o = fwd;
  assign bus.wbm_we_o  = fwd & req_we;
  assign bus.wbm_sel_o = fwd ? req_sel : 4'b0;
  assign bus.wbm_adr_o = fwd ? req_adr : 32'h0;
  assign bus.wbm_dat_o = fwd ? req_dat : 32'h0;
  assign bus.wbs_ack_o = (state == DONE);
  assign bus.wbs_dat_o = (state == DONE) ? cap_dat : 32'h0;
  assign bus.timeout_o = err;
endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Randomized bench for wb_timeout_bridge: a transaction-timeline model predicts
// every output on every cycle; literal checks pin the directed scenarios.
module tb_wb_timeout_bridge;
  localparam int          TIMEOUT     = 16;
  localparam logic [31:0] STATUS_ADDR = 32'h30000F00;
  localparam logic [31:0] ERR_DATA    = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_timeout_bridge_if bus();

  wb_timeout_bridge #(.TIMEOUT(TIMEOUT), .STATUS_ADDR(STATUS_ADDR), .ERR_DATA(ERR_DATA)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  int n_chk = 0, n_fail = 0, cyc_n = 0, g_t0 = 0;
  bit chk_en = 1'b0;

  // per-cycle expected outputs
  logic        e_fwd, e_we, e_ack, e_tmo;
  logic [3:0]  e_sel;
  logic [31:0] e_adr, e_wdat, e_rdat;
  // model of the status register
  logic        m_err  = 1'b0;
  int          m_cnt  = 0;
  logic [15:0] m_last = '0;
  // observations for the literal checks
  int          obs_ack_cyc, obs_ack_n, obs_stb_n;
  logic [31:0] obs_ack_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wbm_cyc", 32'(bus.wbm_cyc_o), 32'(e_fwd));
      chk("wbm_stb", 32'(bus.wbm_stb_o), 32'(e_fwd));
      chk("wbm_adr", bus.wbm_adr_o, e_adr);
      chk("wbm_dat", bus.wbm_dat_o, e_wdat);
      chk("wbm_we_sel", 32'({bus.wbm_we_o, bus.wbm_sel_o}), 32'({e_we, e_sel}));
      chk("wbs_ack", 32'(bus.wbs_ack_o), 32'(e_ack));
      chk("wbs_dat", bus.wbs_dat_o, e_rdat);
      chk("timeout_o", 32'(bus.timeout_o), 32'(e_tmo));
      if (bus.wbs_ack_o === 1'b1) begin
        obs_ack_n++;
        obs_ack_cyc = cyc_n;
        obs_ack_dat = bus.wbs_dat_o;
      end
      if (bus.wbm_stb_o === 1'b1) obs_stb_n++;
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic clear_model();
    m_err = 1'b0; m_cnt = 0; m_last = '0;
  endtask

  // enter the next cycle with default inputs and an idle expectation
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
    rst = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = $urandom;
    e_fwd = 1'b0; e_we = 1'b0; e_sel = '0; e_adr = '0; e_wdat = '0;
    e_ack = 1'b0; e_rdat = '0; e_tmo = m_err;
  endtask

  task automatic master_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'($urandom);
    bus.wbs_sel_i = 4'($urandom);
    bus.wbs_adr_i = $urandom;
    bus.wbs_dat_i = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      master_idle();
      bus.wbm_ack_i = 1'($urandom);
    end
  endtask

  // ack_at: FWD cycle (1-based) in which the harness acks, 0 = never
  // abort_at / rst_at: FWD cycle in which cyc drops / reset pulses, 0 = never
  task automatic xact(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] wdat, input int ack_at, input logic [31:0] rdat,
                      input int abort_at, input int rst_at);
    int win, ackc, last;
    bit is_local, tmo;
    logic [31:0] status;
    is_local = (adr == STATUS_ADDR);
    tmo = 1'b0;
    tick();
    g_t0 = cyc_n; obs_ack_n = 0; obs_stb_n = 0; obs_ack_cyc = -1; obs_ack_dat = '0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = wdat;
    bus.wbm_ack_i = 1'($urandom);
    if (is_local)                          begin win = 0;        ackc = 2;           end
    else if (abort_at > 0)                 begin win = abort_at; ackc = 0;           end
    else if (rst_at > 0)                   begin win = rst_at;   ackc = 0;           end
    else if (ack_at >= 1 && ack_at <= TIMEOUT) begin win = ack_at; ackc = ack_at + 1; end
    else begin win = TIMEOUT; ackc = TIMEOUT + 1; tmo = 1'b1; end
    last = (ackc > 0) ? ackc : win;
    for (int k = 1; k <= last; k++) begin
      tick();
      if (k == abort_at) master_idle();
      rst = (k == rst_at);
      if (k <= win) bus.wbm_ack_i = (k == ack_at);
      else          bus.wbm_ack_i = (k == ack_at) | 1'($urandom);
      if (k == ack_at) bus.wbm_dat_i = rdat;
      if (k <= win) begin
        e_fwd = 1'b1; e_adr = adr; e_wdat = wdat; e_sel = sel; e_we = we;
      end
      if (k == ackc) begin
        if (is_local) begin
          status = {m_err, 7'b0, 8'(m_cnt), m_last};
          e_rdat = we ? 32'h0 : status;
          if (we && sel[3]) clear_model();
        end else if (tmo) begin
          e_rdat = we ? 32'h0 : ERR_DATA;
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
          m_last = adr[15:0];
        end else begin
          e_rdat = we ? 32'h0 : rdat;
        end
        e_ack = 1'b1;
        e_tmo = m_err;
      end
    end
    if (rst_at > 0) clear_model();
  endtask

  initial begin
    int ack_at, abort_at, amax;
    bit we;
    logic [31:0] adr;

    master_idle();
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    tick(); rst = 1'b1; master_idle(); chk_en = 1'b1;
    tick(); rst = 1'b1;
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'h0);
    chk("rst_tmo", 32'(bus.timeout_o), 32'h0);
    tick(); rst = 1'b1;
    idle(2);

    // registered harness read
    xact(1'b0, 4'hF, 32'h30000000, 32'h0, 2, 32'h00000002, 0, 0);
    idle(1);
    chk("t1_latency", 32'(obs_ack_cyc - g_t0), 32'd3);
    chk("t1_data", obs_ack_dat, 32'h00000002);
    chk("t1_tmo", 32'(bus.timeout_o), 32'h0);

    // write that is never acked
    xact(1'b1, 4'hF, 32'h30000300, 32'hCAFE0001, 0, 32'h0, 0, 0);
    idle(1);
    chk("t2_stb_cycles", 32'(obs_stb_n), 32'd16);
    chk("t2_latency", 32'(obs_ack_cyc - g_t0), 32'd17);
    chk("t2_ack_count", 32'(obs_ack_n), 32'd1);
    chk("t2_data", obs_ack_dat, 32'h0);
    chk("t2_tmo", 32'(bus.timeout_o), 32'h1);

    // status register: read, ignored write, clearing write
    xact(1'b0, 4'hF, STATUS_ADDR, 32'h0, 0, 32'h0, 0, 0);
    idle(1);
    chk("t3_status", obs_ack_dat, 32'h80010300);
    chk("t3_latency", 32'(obs_ack_cyc - g_t0), 32'd2);
    chk("t3_no_fwd", 32'(obs_stb_n), 32'd0);
    xact(1'b1, 4'b0111, STATUS_ADDR, 32'hFFFFFFFF, 0, 32'h0, 0, 0);
    xact(1'b0, 4'hF, STATUS_ADDR, 32'h0, 0, 32'h0, 0, 0);
    idle(1);
    chk("t3_status_kept", obs_ack_dat, 32'h80010300);
    xact(1'b1, 4'b1000, STATUS_ADDR, 32'h0, 0, 32'h0, 0, 0);
    xact(1'b0, 4'hF, STATUS_ADDR, 32'h0, 0, 32'h0, 0, 0);
    idle(1);
    chk("t3_status_clr", obs_ack_dat, 32'h0);

    // ack on the limit cycle wins; one cycle later is a timeout with a stale ack
    xact(1'b0, 4'hF, 32'h30000020, 32'h0, TIMEOUT, 32'h12345678, 0, 0);
    idle(1);
    chk("t4_edge_data", obs_ack_dat, 32'h12345678);
    chk("t4_edge_latency", 32'(obs_ack_cyc - g_t0), 32'd17);
    chk("t4_edge_tmo", 32'(bus.timeout_o), 32'h0);
    xact(1'b0, 4'hF, 32'h30000010, 32'h0, TIMEOUT + 1, 32'h55555555, 0, 0);
    idle(1);
    chk("t4_late_data", obs_ack_dat, 32'hDEADBEEF);
    chk("t4_late_ack_count", 32'(obs_ack_n), 32'd1);
    chk("t4_late_tmo", 32'(bus.timeout_o), 32'h1);

    // master abort, then timeout counter saturation
    xact(1'b0, 4'hF, 32'h30000400, 32'h0, 0, 32'h0, 2, 0);
    idle(1);
    chk("t5_abort_stb", 32'(obs_stb_n), 32'd2);
    chk("t5_abort_ack", 32'(obs_ack_n), 32'd0);
    xact(1'b0, 4'hF, STATUS_ADDR, 32'h0, 0, 32'h0, 0, 0);
    idle(1);
    chk("t5_status_after_abort", obs_ack_dat, 32'h80010010);
    for (int i = 0; i < 256; i++) xact(1'b0, 4'hF, 32'h30000500, 32'h0, 0, 32'h0, 0, 0);
    xact(1'b0, 4'hF, STATUS_ADDR, 32'h0, 0, 32'h0, 0, 0);
    idle(1);
    chk("t5_saturated", obs_ack_dat, 32'h80FF0500);

    // reset pulse mid-forward
    xact(1'b0, 4'hF, 32'h30000600, 32'h0, 0, 32'h0, 0, 3);
    idle(1);
    chk("t6_rst_stb", 32'(obs_stb_n), 32'd3);
    chk("t6_rst_ack", 32'(obs_ack_n), 32'd0);
    chk("t6_rst_tmo", 32'(bus.timeout_o), 32'h0);
    xact(1'b0, 4'hF, 32'h30000000, 32'h0, 2, 32'h00000002, 0, 0);
    idle(1);
    chk("t6_after_latency", 32'(obs_ack_cyc - g_t0), 32'd3);
    chk("t6_after_data", obs_ack_dat, 32'h00000002);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) == 0) adr = STATUS_ADDR;
      else adr = {20'h30000, 12'($urandom) & 12'h7FF};
      ack_at = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 1));
      abort_at = 0;
      if (adr != STATUS_ADDR && $urandom_range(0, 7) == 0) begin
        amax = (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at - 1 : TIMEOUT - 1;
        if (amax >= 1) abort_at = int'($urandom_range(1, amax));
      end
      xact(we, 4'($urandom), adr, $urandom, ack_at, $urandom, abort_at, 0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
